// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the cpu_ctrl sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int COND_LO  = 28;
  localparam int CLASS_HI = 27;
  localparam int I_BIT    = 25;
  localparam int L_BIT    = 24;
  localparam int OPC_LO   = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LO    = 16;
  localparam int RD_LO    = 12;
  localparam int RS_LO    = 8;
  localparam int SAMT_LO  = 7;
  localparam int STYP_LO  = 5;
  localparam int SREG_BIT = 4;
  localparam int RM_LO    = 0;

  // Zero-extended imm8 rotated right by twice the 4-bit rotate field.
  function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    dbl = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - fetch handshake and register-bank control bundle
interface cpu_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic [3:0]  cpsr_in;
  logic [3:0]  read_A_select;
  logic [3:0]  read_B_select;
  logic [3:0]  read_C_select;
  logic        read_B_en;
  logic [3:0]  write_select;
  logic        write_en;
  logic        write_pc_en;
  logic        write_lr_en;
  logic        write_cpsr_en;
  logic [3:0]  alu_op;
  logic        set_flags;
  logic        alu_b_sel;
  logic [31:0] imm_out;
  logic [1:0]  shift_type;
  logic [4:0]  shift_amt;
  logic        shift_by_reg;
  logic        halted;

  modport master (
    input  imem_ack, instr_in, cpsr_in,
    output imem_req, read_A_select, read_B_select, read_C_select, read_B_en,
           write_select, write_en, write_pc_en, write_lr_en, write_cpsr_en,
           alu_op, set_flags, alu_b_sel, imm_out, shift_type, shift_amt,
           shift_by_reg, halted
  );

  modport slave (
    output imem_ack, instr_in, cpsr_in,
    input  imem_req, read_A_select, read_B_select, read_C_select, read_B_en,
           write_select, write_en, write_pc_en, write_lr_en, write_cpsr_en,
           alu_op, set_flags, alu_b_sel, imm_out, shift_type, shift_amt,
           shift_by_reg, halted
  );
endinterface

// File: rtl/cpu_ctrl_cond_check.sv
// rtl/cpu_ctrl_cond_check.sv - ARM condition-code evaluation against NZCV
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle fetch/decode/execute/writeback sequencer
// All outputs are Moore, decoded from the state register and IR.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  cpu_ctrl_if.master bus
);
  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic        is_dp, is_br, is_cmp, undef, pass, sel_on;

  logic [3:0]  d_a_sel, d_b_sel, d_c_sel, d_wsel, d_alu_op;
  logic        d_b_en, d_set_flags, d_imm_sel, d_sbr, d_lr;
  logic [31:0] d_imm;
  logic [1:0]  d_stype;
  logic [4:0]  d_samt;

  assign opcode = ir[OPC_LO +: 4];
  assign is_dp  = (ir[CLASS_HI -: 2] == 2'b00);
  assign is_br  = (ir[CLASS_HI -: 3] == 3'b101);
  assign is_cmp = is_dp && (opcode inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
  assign undef  = (ir[COND_LO +: 4] == COND_NV) || !(is_dp || is_br) ||
                  (is_cmp && !ir[S_BIT]);

  cond_check u_cond_check (
    .cond (ir[COND_LO +: 4]),
    .nzcv (bus.cpsr_in),
    .pass (pass)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.imem_ack)
        ir <= bus.instr_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      state_nxt = S_FETCH;
      S_FETCH:     state_nxt = bus.imem_ack ? S_DECODE : S_FETCH;
      S_DECODE:    state_nxt = undef ? S_HALT : (pass ? S_EXECUTE : S_FETCH);
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    d_a_sel     = '0;
    d_b_sel     = '0;
    d_c_sel     = '0;
    d_wsel      = '0;
    d_alu_op    = '0;
    d_b_en      = 1'b0;
    d_set_flags = 1'b0;
    d_imm_sel   = 1'b0;
    d_sbr       = 1'b0;
    d_lr        = 1'b0;
    d_imm       = '0;
    d_stype     = '0;
    d_samt      = '0;
    if (is_br) begin
      // B/BL computes PC + offset; PC already points at instruction + 4.
      d_a_sel   = 4'd15;
      d_alu_op  = OP_ADD;
      d_imm_sel = 1'b1;
      d_imm     = {{6{ir[23]}}, ir[23:0], 2'b00};
      d_wsel    = 4'd15;
      d_lr      = ir[L_BIT];
    end else if (is_dp) begin
      d_a_sel     = ir[RN_LO +: 4];
      d_wsel      = ir[RD_LO +: 4];
      d_alu_op    = opcode;
      d_set_flags = ir[S_BIT];
      if (ir[I_BIT]) begin
        d_imm_sel = 1'b1;
        d_imm     = rot_imm(ir[7:0], ir[11:8]);
      end else begin
        d_b_sel = ir[RM_LO +: 4];
        d_b_en  = 1'b1;
        d_stype = ir[STYP_LO +: 2];
        if (ir[SREG_BIT]) begin
          d_c_sel = ir[RS_LO +: 4];
          d_sbr   = 1'b1;
        end else begin
          d_samt  = ir[SAMT_LO +: 5];
        end
      end
    end
  end

  assign sel_on = (state == S_DECODE) || (state == S_EXECUTE) || (state == S_WRITEBACK);

  always_comb begin
    bus.imem_req      = 1'b0;
    bus.write_en      = 1'b0;
    bus.write_pc_en   = 1'b0;
    bus.write_lr_en   = 1'b0;
    bus.write_cpsr_en = 1'b0;
    bus.halted        = 1'b0;
    bus.read_A_select = sel_on ? d_a_sel     : 4'd0;
    bus.read_B_select = sel_on ? d_b_sel     : 4'd0;
    bus.read_C_select = sel_on ? d_c_sel     : 4'd0;
    bus.read_B_en     = sel_on && d_b_en;
    bus.write_select  = sel_on ? d_wsel      : 4'd0;
    bus.alu_op        = sel_on ? d_alu_op    : 4'd0;
    bus.set_flags     = sel_on && d_set_flags;
    bus.alu_b_sel     = sel_on && d_imm_sel;
    bus.imm_out       = sel_on ? d_imm       : 32'd0;
    bus.shift_type    = sel_on ? d_stype     : 2'd0;
    bus.shift_amt     = sel_on ? d_samt      : 5'd0;
    bus.shift_by_reg  = sel_on && d_sbr;
    case (state)
      S_FETCH:  bus.imem_req    = 1'b1;
      S_DECODE: bus.write_pc_en = 1'b1;
      S_WRITEBACK: begin
        bus.write_en      = !is_cmp;
        bus.write_cpsr_en = d_set_flags || is_cmp;
        bus.write_lr_en   = d_lr;
      end
      S_HALT:   bus.halted      = 1'b1;
      default:  ;
    endcase
  end
endmodule
